// File: rtl/vend_if.sv
// rtl/vend_if.sv - vending controller button, switch, LED, credit and LCD handshake bundle
interface vend_if;
  logic       botao0;
  logic       botao1;
  logic       botao2;
  logic       botao;
  logic [3:0] chave4;
  logic       led0;
  logic       led1;
  logic       led2;
  logic       led3;
  logic [7:0] credit;
  logic [7:0] change;
  logic       disp_req;
  logic       disp_ack;
  logic [3:0] disp_code;

  modport slave (
    input  botao0, botao1, botao2, botao, chave4, disp_ack,
    output led0, led1, led2, led3, credit, change, disp_req, disp_code
  );

  modport master (
    output botao0, botao1, botao2, botao, chave4, disp_ack,
    input  led0, led1, led2, led3, credit, change, disp_req, disp_code
  );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin vending FSM with debounced buttons and coalescing LCD message handshake
module vend_controller #(
  parameter int PRICE0          = 3,
  parameter int PRICE1          = 5,
  parameter int PRICE2          = 7,
  parameter int PRICE3          = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DISPENSE_CYCLES = 50000000,
  parameter int CHANGE_CYCLES   = 50000000
) (
  input logic iCLK_50MHZ,
  input logic iRST_N,
  vend_if.slave bus
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_MAX = (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
  localparam int TM_W   = $clog2(TM_MAX + 1);

  localparam logic [3:0] C_IDLE = 4'd0, C_CREDIT = 4'd1, C_DISPENSE = 4'd2,
                         C_CHANGE = 4'd3, C_REJECT = 4'd4, C_SELERR = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

  // button order: 0 coin1, 1 coin2, 2 coin5, 3 cancel
  logic [3:0]      w_btn;
  logic [3:0]      r_sync1, r_sync2, r_stable, r_pulse;
  logic [DB_W-1:0] r_db_cnt [4];

  assign w_btn = {bus.botao, bus.botao2, bus.botao1, bus.botao0};

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_pulse  <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_cnt[i] <= '0;
          r_stable[i] <= r_sync2[i];
          r_pulse[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t          r_state;
  logic [7:0]      r_credit, r_change;
  logic [3:0]      r_led, r_sel_prev, r_msg_code;
  logic            r_msg_v;
  logic [TM_W-1:0] r_timer;

  logic [7:0] w_sum, w_price;
  logic [8:0] w_total;
  logic [2:0] w_sel_cnt;
  logic [1:0] w_sel_idx;
  logic       w_sel_valid, w_sel_multi, w_cancel;

  always_comb begin
    w_sel_cnt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < 4; i++) begin
      w_sel_cnt = w_sel_cnt + {2'b00, bus.chave4[i]};
      if (bus.chave4[i]) w_sel_idx = 2'(i);
    end
    w_sel_valid = (w_sel_cnt == 3'd1);
    w_sel_multi = (w_sel_cnt > 3'd1);
    case (w_sel_idx)
      2'd0:    w_price = 8'(PRICE0);
      2'd1:    w_price = 8'(PRICE1);
      2'd2:    w_price = 8'(PRICE2);
      default: w_price = 8'(PRICE3);
    endcase
    w_sum = (r_pulse[0] ? 8'd1 : 8'd0) + (r_pulse[1] ? 8'd2 : 8'd0) + (r_pulse[2] ? 8'd5 : 8'd0);
    w_total  = {1'b0, r_credit} + {1'b0, w_sum};
    w_cancel = r_pulse[3];
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_change   <= '0;
      r_led      <= '0;
      r_timer    <= '0;
      r_sel_prev <= '0;
      r_msg_v    <= 1'b0;
      r_msg_code <= C_IDLE;
    end else begin
      r_msg_v    <= 1'b0;
      r_sel_prev <= bus.chave4;
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (r_state == S_COLLECT && w_cancel) begin
            r_change   <= r_credit;
            r_credit   <= '0;
            r_timer    <= '0;
            r_state    <= S_CHANGE;
            r_msg_v    <= 1'b1;
            r_msg_code <= C_CHANGE;
          end else if (w_sum != 8'd0) begin
            r_msg_v <= 1'b1;
            if (w_total > 9'd255) begin
              r_msg_code <= C_REJECT;
            end else begin
              r_credit   <= w_total[7:0];
              r_state    <= S_COLLECT;
              r_msg_code <= C_CREDIT;
            end
          end else if (r_state == S_COLLECT && w_sel_valid && r_credit >= w_price) begin
            r_change          <= r_credit - w_price;
            r_credit          <= '0;
            r_led[w_sel_idx]  <= 1'b1;
            r_timer           <= '0;
            r_state           <= S_DISPENSE;
            r_msg_v           <= 1'b1;
            r_msg_code        <= C_DISPENSE;
          end else if (w_sel_multi && bus.chave4 != r_sel_prev) begin
            r_msg_v    <= 1'b1;
            r_msg_code <= C_SELERR;
          end
        end
        S_DISPENSE: begin
          if (r_timer == TM_W'(DISPENSE_CYCLES - 1)) begin
            r_led      <= '0;
            r_timer    <= '0;
            r_state    <= S_CHANGE;
            r_msg_v    <= 1'b1;
            r_msg_code <= C_CHANGE;
          end else begin
            r_timer <= r_timer + TM_W'(1);
          end
        end
        S_CHANGE: begin
          if (r_timer == TM_W'(CHANGE_CYCLES - 1)) begin
            r_change   <= '0;
            r_timer    <= '0;
            r_state    <= S_IDLE;
            r_msg_v    <= 1'b1;
            r_msg_code <= C_IDLE;
          end else begin
            r_timer <= r_timer + TM_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_boot announces IDLE on the first cycle out of reset
  logic       r_boot, r_req, r_pend_v;
  logic [3:0] r_code, r_pend_code;
  logic       w_new_v;
  logic [3:0] w_new_code;

  assign w_new_v    = r_boot | r_msg_v;
  assign w_new_code = r_boot ? C_IDLE : r_msg_code;

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_boot      <= 1'b1;
      r_req       <= 1'b0;
      r_code      <= C_IDLE;
      r_pend_v    <= 1'b0;
      r_pend_code <= C_IDLE;
    end else begin
      r_boot <= 1'b0;
      if (r_req) begin
        if (bus.disp_ack) r_req <= 1'b0;
        if (w_new_v) begin
          r_pend_v    <= 1'b1;
          r_pend_code <= w_new_code;
        end
      end else if (w_new_v) begin
        r_req    <= 1'b1;
        r_code   <= w_new_code;
        r_pend_v <= 1'b0;
      end else if (r_pend_v) begin
        r_req    <= 1'b1;
        r_code   <= r_pend_code;
        r_pend_v <= 1'b0;
      end
    end
  end

  assign bus.led0      = r_led[0];
  assign bus.led1      = r_led[1];
  assign bus.led2      = r_led[2];
  assign bus.led3      = r_led[3];
  assign bus.credit    = r_credit;
  assign bus.change    = r_change;
  assign bus.disp_req  = r_req;
  assign bus.disp_code = r_code;
endmodule
